// File: rtl/stochastic_stream_decoder.sv
// Counts the ones in one BIT_LENGTH-bit stochastic stream and returns the count
// through a valid/ready handshake. Optional signed bipolar output: STOCH_DEC_BIPOLAR_EN.
module stochastic_stream_decoder #(
    parameter int BIT_LENGTH = 128,
    parameter int CNT_W      = $clog2(BIT_LENGTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    in_valid,
    input  logic                    in_bit,
    output logic                    busy,
    output logic [CNT_W-1:0]        bit_idx,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CNT_W-1:0]        ones_count,
    output logic signed [CNT_W:0]   bipolar_value
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BIT_LENGTH - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] acc;
    logic [CNT_W-1:0] acc_sum;
    logic             accept;
    logic             last;
    logic             clear;

    assign acc_sum   = acc + CNT_W'(in_bit);
    assign busy      = (state == ACCUM);
    assign out_valid = (state == HOLD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // abort wins over a last bit arriving in the same cycle
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last      = 1'b0;
        clear     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = ACCUM;
                    clear     = 1'b1;
                end
            end
            ACCUM: begin
                if (abort) begin
                    state_nxt = IDLE;
                    clear     = 1'b1;
                end else if (in_valid) begin
                    accept = 1'b1;
                    if (bit_idx == LAST_IDX) begin
                        last      = 1'b1;
                        state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    if (start) begin
                        state_nxt = ACCUM;
                        clear     = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            bit_idx <= '0;
        end else if (clear) begin
            acc     <= '0;
            bit_idx <= '0;
        end else if (accept) begin
            acc     <= acc_sum;
            bit_idx <= bit_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    ones_count <= '0;
        else if (last) ones_count <= acc_sum;
    end

`ifdef STOCH_DEC_BIPOLAR_EN
    // 2*ones - BIT_LENGTH; modular CNT_W+1-bit arithmetic lands in range
    logic [CNT_W:0] bip_nxt;
    assign bip_nxt = {acc_sum, 1'b0} - (CNT_W+1)'(BIT_LENGTH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    bipolar_value <= '0;
        else if (last) bipolar_value <= bip_nxt;
    end
`else
    assign bipolar_value = '0;
`endif

endmodule

// File: tb/tb_stochastic_stream_decoder.sv
// Randomized self-checking bench for stochastic_stream_decoder; expected counts
// come from counting the ones in each generated stream pattern.
module tb_stochastic_stream_decoder;

    localparam int BL = 128;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic in_valid = 1'b0;
    logic in_bit = 1'b0;
    logic out_ready = 1'b0;
    logic busy;
    logic out_valid;
    logic [CW-1:0] bit_idx;
    logic [CW-1:0] ones_count;
    logic signed [CW:0] bipolar_value;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int prev_ones = 0;

    always #5 clk = ~clk;

    stochastic_stream_decoder #(.BIT_LENGTH(BL), .CNT_W(CW)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .abort(abort),
        .in_valid(in_valid),
        .in_bit(in_bit),
        .busy(busy),
        .bit_idx(bit_idx),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .ones_count(ones_count),
        .bipolar_value(bipolar_value)
    );

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_bip(input int ones);
`ifdef STOCH_DEC_BIPOLAR_EN
        return 2 * ones - BL;
`else
        return 0;
`endif
    endfunction

    function automatic int count_ones(input logic [BL-1:0] p);
        int n = 0;
        for (int i = 0; i < BL; i++) n += int'(p[i]);
        return n;
    endfunction

    function automatic logic [BL-1:0] rand_pat(input int dens);
        logic [BL-1:0] p;
        for (int i = 0; i < BL; i++) p[i] = ($urandom_range(99) < dens);
        return p;
    endfunction

    // All tasks start and end just after a falling edge.
    task automatic kick();
        start = 1'b1;
        in_valid = 1'b1;
        in_bit = 1'b1;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b0;
        cyc = 1;
    endtask

    // mode 0: continuous, 3: in_valid low every 3rd cycle, 1: random stalls
    task automatic feed(input logic [BL-1:0] pat, input int n, input int mode);
        int c;
        c = 0;
        for (int i = 0; i < n; i++) begin
            while ((mode == 3 && c % 3 == 2) || (mode == 1 && $urandom_range(3) == 0)) begin
                in_valid = 1'b0;
                in_bit = 1'($urandom_range(1));
                @(negedge clk);
                cyc++;
                c++;
                chk("stall_idx", bit_idx, i);
            end
            in_valid = 1'b1;
            in_bit = pat[i];
            @(negedge clk);
            cyc++;
            c++;
            if (i != BL - 1) begin
                chk("early_valid", out_valid, 0);
                chk("bit_idx", bit_idx, i + 1);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic result(input string tag, input int ones);
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_ones"}, ones_count, ones);
        chk({tag, "_bip"}, bipolar_value, exp_bip(ones));
        prev_ones = ones;
    endtask

    task automatic release_res(input logic nxt);
        out_ready = 1'b1;
        start = nxt;
        @(negedge clk);
        out_ready = 1'b0;
        start = 1'b0;
        if (nxt) begin
            chk("b2b_busy", busy, 1);
            chk("b2b_valid", out_valid, 0);
            cyc = 1;
        end else begin
            chk("idle_valid", out_valid, 0);
            chk("idle_busy", busy, 0);
        end
    endtask

    initial begin
        logic [BL-1:0] p;
        logic chain;
        int ones;

        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_idx", bit_idx, 0);
        chk("rst_ones", ones_count, 0);
        chk("rst_bip", bipolar_value, 0);
        rst_n = 1'b1;
        @(negedge clk);

        p = '1;
        kick();
        feed(p, BL, 0);
        chk("lat_ones", cyc, BL + 1);
        result("all1", BL);
        release_res(1'b0);

        p = '0;
        kick();
        feed(p, BL, 0);
        chk("lat_zeros", cyc, BL + 1);
        result("all0", 0);
        release_res(1'b0);

        for (int i = 0; i < BL; i++) p[i] = (i % 2 == 0);
        kick();
        feed(p, BL, 3);
        result("alt", 64);

        // results must survive start and abort while the consumer stalls
        for (int k = 0; k < 10; k++) begin
            start = (k == 4);
            abort = (k == 6);
            in_valid = 1'b1;
            in_bit = 1'b1;
            @(negedge clk);
            chk("hold_valid", out_valid, 1);
            chk("hold_busy", busy, 0);
            chk("hold_ones", ones_count, 64);
            chk("hold_bip", bipolar_value, exp_bip(64));
        end
        start = 1'b0;
        abort = 1'b0;
        in_valid = 1'b0;
        release_res(1'b1);
        p = rand_pat(30);
        feed(p, BL, 0);
        chk("lat_b2b", cyc, BL + 1);
        result("b2b", count_ones(p));
        release_res(1'b0);

        p = '1;
        kick();
        feed(p, 50, 0);
        abort = 1'b1;
        in_valid = 1'b1;
        in_bit = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        in_valid = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_idx", bit_idx, 0);
        chk("abort_valid", out_valid, 0);
        chk("abort_ones", ones_count, prev_ones);
        p = '0;
        p[31:0] = '1;
        kick();
        feed(p, BL, 0);
        result("post_abort", 32);
        release_res(1'b0);

        p = rand_pat(70);
        kick();
        feed(p, 70, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_valid", out_valid, 0);
        chk("arst_idx", bit_idx, 0);
        chk("arst_ones", ones_count, 0);
        chk("arst_bip", bipolar_value, 0);
        @(negedge clk);
        rst_n = 1'b1;
        prev_ones = 0;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_bit = 1'b1;
            @(negedge clk);
            chk("idle_ign_busy", busy, 0);
            chk("idle_ign_idx", bit_idx, 0);
            chk("idle_ign_valid", out_valid, 0);
        end
        in_valid = 1'b0;

        chain = 1'b0;
        for (int s = 0; s < 20; s++) begin
            p = rand_pat($urandom_range(100));
            ones = count_ones(p);
            if (!chain) kick();
            feed(p, BL, 1);
            result("rnd", ones);
            repeat ($urandom_range(3)) begin
                @(negedge clk);
                chk("rnd_hold", ones_count, prev_ones);
            end
            chain = 1'($urandom_range(1));
            release_res(chain);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stochastic_stream_decoder.md
# stochastic_stream_decoder

Downstream consumer of the stochastic arithmetic stages (adder/subtractor/multiplier). It counts the ones in one fixed-length stochastic bitstream of BIT_LENGTH bits, arriving one bit per accepted cycle, and returns the result as a binary unipolar count. When compiled in, it also returns a signed bipolar value. Results leave through a valid/ready handshake, so one instance decodes stream after stream for the software-comparison flow.

## Interface
- BIT_LENGTH, 128, bits per stream; must be ≥ 2.
- CNT_W, $clog2(BIT_LENGTH+1), width of ones count (8 at default).
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request to begin a new stream; sampled only when able to start (see Operation).
- abort  input  1  synchronous abort: discards the in-progress stream.
- in_valid  input  1  in_bit is a stream bit this cycle.
- in_bit  input  1  stochastic bit (e.g. subtractor output y).
- busy  output  1  high in ACCUM.
- bit_idx  output  CNT_W  count of bits accepted so far in current stream.
- out_valid  output  1  result registers hold a completed stream.
- out_ready  input  1  consumer accepts the result.
- ones_count  output  CNT_W  number of ones in the last completed stream, range 0..BIT_LENGTH.
- bipolar_value  output  CNT_W+1  signed 2·ones_count − BIT_LENGTH (see Configuration).

## Operation
- States:
  - IDLE: busy=0, out_valid=0.
  - ACCUM: busy=1.
  - HOLD: out_valid=1.
- IDLE → ACCUM on start=1. The transition clears the accumulator and bit_idx.
- ACCUM accepts a bit on each cycle with in_valid=1:
  - accumulator += in_bit;
  - bit_idx += 1.
- ACCUM cycles with in_valid=0 are stalls: no state change.
- The accepted bit with bit_idx==BIT_LENGTH−1 is the last bit. On that edge:
  - ones_count ← accumulator + in_bit;
  - bipolar_value is updated from ones_count;
  - state → HOLD.
- HOLD: ones_count/bipolar_value stay stable until out_valid && out_ready.
  - On the handshake with start=1 in the same cycle: go directly to ACCUM with accumulator cleared. No IDLE bubble.
  - On the handshake with start=0: go to IDLE.
- start is ignored in ACCUM, and in HOLD without out_ready.
- in_valid is ignored outside ACCUM, including the cycle in which start is sampled.
- abort=1 in ACCUM → IDLE. Accumulator and bit_idx are cleared; ones_count keeps its previous value.
  - abort has priority over a simultaneous last bit.
  - abort in IDLE or HOLD has no effect. HOLD results are never discarded.
- Arithmetic widths:
  - The accumulator is CNT_W bits and cannot overflow, since max = BIT_LENGTH.
  - bipolar_value is computed in CNT_W+1-bit two's complement: {1'b0,ones_count,1'b0}-trimmed shift minus BIT_LENGTH. Range −BIT_LENGTH..+BIT_LENGTH.
- Reset, asynchronous, at any point including mid-stream:
  - state=IDLE;
  - busy=0, out_valid=0, bit_idx=0;
  - accumulator=0, ones_count=0, bipolar_value=0.

## Timing
- Registered outputs only; no combinational input→output path.
- Latency:
  - last accepted bit on edge N → out_valid=1 after edge N;
  - minimum stream time is BIT_LENGTH+1 cycles from start to out_valid.
- Back-to-back throughput, with continuous in_valid and out_ready held high with start: one result per BIT_LENGTH+1 cycles.
- busy rises the edge after start is sampled and falls on the edge the last bit or abort is taken.

## Configuration
- STOCH_DEC_BIPOLAR_EN defined:
  - bipolar_value register and subtractor are built;
  - it updates together with ones_count.
- Not defined:
  - no bipolar logic;
  - bipolar_value port is present, tied to 0;
  - ones_count behaviour is unchanged.

## Test plan
All tests use BIT_LENGTH=128 with STOCH_DEC_BIPOLAR_EN defined.
- 128 ones, continuous in_valid → out_valid 129 cycles after start; ones_count=128, bipolar=+128.
- 128 zeros → ones_count=0, bipolar=−128.
- Alternating 1,0 with in_valid low on every 3rd cycle → ones_count=64, bipolar=0; out_valid only after the 128th accepted bit.
- out_ready low for 10 cycles after completion, start pulsed in between → outputs stable, start ignored. Then out_ready=1 with start=1 → next stream starts with no IDLE cycle.
- abort at bit 50, then a new stream of 32 ones + 96 zeros → ones_count=32, bipolar=−64.
- rst_n low at bit 70 → all outputs 0 immediately. After release: IDLE, and in_valid is ignored until start.
